// File: rtl/wb_commit_buffer.sv
// In-order writeback buffer: dual allocate, dual out-of-order
// completion, up to two in-order retires per cycle onto the regfile.
module wb_commit_buffer #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              alloc_valid_1,
  input  logic              alloc_valid_2,
  input  logic [REG_W-1:0]  alloc_rd_1,
  input  logic [REG_W-1:0]  alloc_rd_2,
  input  logic              alloc_we_1,
  input  logic              alloc_we_2,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag_1,
  output logic [TAG_W-1:0]  alloc_tag_2,
  input  logic              cmp_valid_a,
  input  logic              cmp_valid_b,
  input  logic [TAG_W-1:0]  cmp_tag_a,
  input  logic [TAG_W-1:0]  cmp_tag_b,
  input  logic [DATA_W-1:0] cmp_data_a,
  input  logic [DATA_W-1:0] cmp_data_b,
  output logic [REG_W-1:0]  rd_1,
  output logic [REG_W-1:0]  rd_2,
  output logic [DATA_W-1:0] writedata_1,
  output logic [DATA_W-1:0] writedata_2,
  output logic              reg_write_1,
  output logic              reg_write_2,
  output logic [TAG_W:0]    count,
  output logic              empty
);

  localparam logic [TAG_W:0] MAX_FILL = (TAG_W+1)'(DEPTH - 2);

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  done_q;
  logic [DEPTH-1:0]  we_q;
  logic [REG_W-1:0]  rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [TAG_W-1:0]  head_q;
  logic [TAG_W-1:0]  tail_q;
  logic [TAG_W:0]    count_q;

  logic [TAG_W-1:0] head_1;
  logic [TAG_W-1:0] tail_1;
  logic             ret_1;
  logic             ret_2;
  logic             wr_1;
  logic             wr_2;
  logic             same_rd;
  logic             do_a1;
  logic             do_a2;
  logic             cmp_a_ok;
  logic             cmp_b_ok;
  logic [TAG_W:0]   alloc_n;
  logic [TAG_W:0]   ret_n;

  assign head_1 = head_q + TAG_W'(1);
  assign tail_1 = tail_q + TAG_W'(1);

  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign alloc_ready = (count_q <= MAX_FILL);
  assign alloc_tag_1 = tail_q;
  assign alloc_tag_2 = tail_1;

  // Retire decode from registered state; port 2 only follows port 1.
  always_comb begin
    ret_1   = 1'b0;
    ret_2   = 1'b0;
    wr_1    = 1'b0;
    wr_2    = 1'b0;
    same_rd = 1'b0;
    ret_1   = valid_q[head_q] & done_q[head_q];
    ret_2   = ret_1 & valid_q[head_1] & done_q[head_1];
    wr_1    = we_q[head_q] & (rd_q[head_q] != '0);
    wr_2    = we_q[head_1] & (rd_q[head_1] != '0);
    same_rd = (rd_q[head_q] == rd_q[head_1]);
  end

  // Allocation and completion qualifiers; pipe A owns a shared tag.
  always_comb begin
    do_a1    = alloc_valid_1 & alloc_ready;
    do_a2    = do_a1 & alloc_valid_2;
    cmp_a_ok = cmp_valid_a & valid_q[cmp_tag_a]
             & ~done_q[cmp_tag_a];
    cmp_b_ok = cmp_valid_b & valid_q[cmp_tag_b]
             & ~done_q[cmp_tag_b]
             & ~(cmp_valid_a && cmp_tag_a == cmp_tag_b);
    alloc_n  = (TAG_W+1)'(do_a1) + (TAG_W+1)'(do_a2);
    ret_n    = (TAG_W+1)'(ret_1) + (TAG_W+1)'(ret_2);
  end

  // Entry table, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (ret_1) valid_q[head_q] <= 1'b0;
      if (ret_2) valid_q[head_1] <= 1'b0;
      if (do_a1) begin
        valid_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        we_q[tail_q]    <= alloc_we_1;
        rd_q[tail_q]    <= alloc_rd_1;
      end
      if (do_a2) begin
        valid_q[tail_1] <= 1'b1;
        done_q[tail_1]  <= 1'b0;
        we_q[tail_1]    <= alloc_we_2;
        rd_q[tail_1]    <= alloc_rd_2;
      end
      if (cmp_a_ok) begin
        done_q[cmp_tag_a] <= 1'b1;
        data_q[cmp_tag_a] <= cmp_data_a;
      end
      if (cmp_b_ok) begin
        done_q[cmp_tag_b] <= 1'b1;
        data_q[cmp_tag_b] <= cmp_data_b;
      end
      head_q  <= head_q + ret_n[TAG_W-1:0];
      tail_q  <= tail_q + alloc_n[TAG_W-1:0];
      count_q <= count_q + alloc_n - ret_n;
    end
  end

  // Registered write ports; younger result wins a shared rd.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_1        <= '0;
      rd_2        <= '0;
      writedata_1 <= '0;
      writedata_2 <= '0;
      reg_write_1 <= 1'b0;
      reg_write_2 <= 1'b0;
    end else if (flush) begin
      reg_write_1 <= 1'b0;
      reg_write_2 <= 1'b0;
    end else begin
      reg_write_1 <= ret_1 & wr_1
                   & ~(ret_2 & wr_2 & same_rd);
      reg_write_2 <= ret_2 & wr_2;
      if (ret_1) begin
        rd_1        <= rd_q[head_q];
        writedata_1 <= data_q[head_q];
      end
      if (ret_2) begin
        rd_2        <= rd_q[head_1];
        writedata_2 <= data_q[head_1];
      end
    end
  end

endmodule
